// File: rtl/ackfifo_pkg.sv
// Shared helpers for the ackfifo controller and its storage RAM.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
// Contents: clog2, depth derivation from address bits, threshold range checks.
package ackfifo_pkg;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Number of RAM entries for a given number of address bits.
  function automatic int depth_of(input int rdepth);
    return 1 << rdepth;
  endfunction

  // afull threshold must lie in 1..DEPTH.
  function automatic bit af_thresh_ok(input int af_thresh, input int depth);
    return (af_thresh >= 1) && (af_thresh <= depth);
  endfunction

  // aempty threshold must lie in 0..DEPTH-1.
  function automatic bit ae_thresh_ok(input int ae_thresh, input int depth);
    return (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage : ackfifo_pkg

// File: rtl/ackfifo_sync_ram.sv
// Simple dual-port storage RAM: one write port, one registered read port.
// Latency: read data appears one cycle after re; write visible to a read on the next edge.
// Backpressure: none; the controller guarantees it never reads an unwritten slot.
// Ports:
//   pos_rclk          clock (shared by both ports)
//   we, waddr, din    write port
//   re, raddr, dout   read port; dout holds when re is low, no reset so it maps to fabric RAM
module ackfifo_sync_ram
  import ackfifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 10
) (
  input  logic                    pos_rclk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        din,
  input  logic                    re,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        dout
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge pos_rclk) begin
    if (we) begin
      mem_q[waddr] <= din;
    end
  end

  // Read-before-write is irrelevant here: the controller never reads and
  // writes the same slot in one cycle.
  always_ff @(posedge pos_rclk) begin
    if (re) begin
      dout_q <= mem_q[raddr];
    end
  end

  assign dout = dout_q;

endmodule : ackfifo_sync_ram

// File: rtl/ackfifo_sync_ctrl.sv
// Single-clock FIFO controller + storage feeding the FWFT stage.
// Latency: fifo_dout valid one cycle after an accepted fifo_rd_en; flags/status exact the cycle after the edge.
// Backpressure: writes dropped when full (overflow pulse), reads dropped when empty (underflow pulse).
// Ports:
//   pos_rclk, aresetn                 clock, async active-low reset
//   wr_en, din                        write request and data
//   fifo_rd_en                        read request from the FWFT stage
//   fifo_dout, fifo_MEMRADDR          read data, RAM address of the next word to be read
//   fifo_empty, fifo_aempty           read-side flags (registered)
//   full, afull, count                write-side flags and occupancy
//   wr_ack, overflow, underflow       one-cycle status pulses about the previous cycle
module ackfifo_sync_ctrl
  import ackfifo_pkg::*;
#(
  parameter int RDEPTH    = 4,
  parameter int WIDTH     = 10,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic              pos_rclk,
  input  logic              aresetn,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  din,
  input  logic              fifo_rd_en,
  output logic [WIDTH-1:0]  fifo_dout,
  output logic              fifo_empty,
  output logic              fifo_aempty,
  output logic              full,
  output logic              afull,
  output logic              wr_ack,
  output logic              overflow,
  output logic              underflow,
  output logic [RDEPTH:0]   count,
  output logic [RDEPTH-1:0] fifo_MEMRADDR
);

  localparam int DEPTH = depth_of(RDEPTH);
  localparam int PW    = RDEPTH + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C    = PW'(AE_THRESH);

  // Elaboration-time parameter sanity.
  if (RDEPTH < 2) begin : g_bad_rdepth
    $error("ackfifo_sync_ctrl: RDEPTH must be >= 2");
  end
  if (!af_thresh_ok(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("ackfifo_sync_ctrl: AF_THRESH out of range 1..DEPTH");
  end
  if (!ae_thresh_ok(AE_THRESH, DEPTH)) begin : g_bad_ae
    $error("ackfifo_sync_ctrl: AE_THRESH out of range 0..DEPTH-1");
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] count_d;

  logic empty_q,     empty_d;
  logic aempty_q,    aempty_d;
  logic full_q,      full_d;
  logic afull_q,     afull_d;
  logic wr_ack_q,    wr_ack_d;
  logic overflow_q,  overflow_d;
  logic underflow_q, underflow_d;

  // Set by the first accepted read after reset; gates the unreset RAM output
  // so fifo_dout reads zero until real data has been fetched.
  logic dout_seen_q, dout_seen_d;

  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] ram_dout;

  // Accept decisions depend on registered flags only, so there is no
  // combinational path from wr_en into the read side (no bypass).
  assign wr_ok = wr_en & ~full_q;
  assign rd_ok = fifo_rd_en & ~empty_q;

  always_comb begin
    wptr_d      = wptr_q + {{RDEPTH{1'b0}}, wr_ok};
    rptr_d      = rptr_q + {{RDEPTH{1'b0}}, rd_ok};
    count_d     = wptr_d - rptr_d;

    empty_d     = (count_d == '0);
    full_d      = (count_d == DEPTH_C);
    afull_d     = (count_d >= AF_C);
    aempty_d    = (count_d <= AE_C);

    wr_ack_d    = wr_ok;
    overflow_d  = wr_en & full_q;
    underflow_d = fifo_rd_en & empty_q;

    dout_seen_d = dout_seen_q | rd_ok;
  end

  always_ff @(posedge pos_rclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      dout_seen_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      empty_q     <= empty_d;
      aempty_q    <= aempty_d;
      full_q      <= full_d;
      afull_q     <= afull_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      dout_seen_q <= dout_seen_d;
    end
  end

  ackfifo_sync_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_ram (
    .pos_rclk (pos_rclk),
    .we       (wr_ok),
    .waddr    (wptr_q[RDEPTH-1:0]),
    .din      (din),
    .re       (rd_ok),
    .raddr    (rptr_q[RDEPTH-1:0]),
    .dout     (ram_dout)
  );

  assign fifo_dout     = dout_seen_q ? ram_dout : '0;
  assign fifo_MEMRADDR = rptr_q[RDEPTH-1:0];
  assign count         = wptr_q - rptr_q;
  assign fifo_empty    = empty_q;
  assign fifo_aempty   = aempty_q;
  assign full          = full_q;
  assign afull         = afull_q;
  assign wr_ack        = wr_ack_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

endmodule : ackfifo_sync_ctrl

// File: tb/tb_ackfifo_sync_ctrl.sv
// Scoreboard bench for ackfifo_sync_ctrl: a queue-based reference model
// predicts the post-edge outputs of every driven cycle; a monitor compares.
module tb_ackfifo_sync_ctrl;

  localparam int RDEPTH = 4;
  localparam int WIDTH  = 10;
  localparam int AF     = 14;
  localparam int AE     = 2;
  localparam int DEPTH  = 16;

  logic              pos_rclk;
  logic              aresetn;
  logic              wr_en;
  logic [WIDTH-1:0]  din;
  logic              fifo_rd_en;
  logic [WIDTH-1:0]  fifo_dout;
  logic              fifo_empty;
  logic              fifo_aempty;
  logic              full;
  logic              afull;
  logic              wr_ack;
  logic              overflow;
  logic              underflow;
  logic [RDEPTH:0]   count;
  logic [RDEPTH-1:0] fifo_MEMRADDR;

  ackfifo_sync_ctrl #(
    .RDEPTH    (RDEPTH),
    .WIDTH     (WIDTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .pos_rclk      (pos_rclk),
    .aresetn       (aresetn),
    .wr_en         (wr_en),
    .din           (din),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_aempty   (fifo_aempty),
    .full          (full),
    .afull         (afull),
    .wr_ack        (wr_ack),
    .overflow      (overflow),
    .underflow     (underflow),
    .count         (count),
    .fifo_MEMRADDR (fifo_MEMRADDR)
  );

  initial pos_rclk = 1'b0;
  always #5 pos_rclk = ~pos_rclk;

  typedef struct {
    int dout;
    int cnt;
    int empty;
    int aempty;
    int full;
    int afull;
    int ack;
    int ovf;
    int udf;
    int raddr;
  } exp_t;

  exp_t sb[$];

  // Reference model: contents as a plain queue, plus last value read out
  // and the total number of accepted reads (gives the next RAM address).
  int   model_q[$];
  int   last_dout;
  int   total_reads;

  int checks;
  int errors;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    last_dout   = 0;
    total_reads = 0;
  endtask

  // Drive one cycle of stimulus and push the expected post-edge state.
  task automatic cycle(input bit wr, input int d, input bit rd);
    exp_t e;
    int   n;
    bit   wacc;
    bit   racc;
    @(negedge pos_rclk);
    wr_en      = wr;
    din        = WIDTH'(d);
    fifo_rd_en = rd;
    n    = model_q.size();
    wacc = wr && (n != DEPTH);
    racc = rd && (n != 0);
    if (racc) begin
      last_dout = model_q.pop_front();
      total_reads++;
    end
    if (wacc) model_q.push_back(d & 'h3FF);
    e.cnt    = model_q.size();
    e.empty  = (e.cnt == 0);
    e.full   = (e.cnt == DEPTH);
    e.afull  = (e.cnt >= AF);
    e.aempty = (e.cnt <= AE);
    e.ack    = wacc;
    e.ovf    = wr && (n == DEPTH);
    e.udf    = rd && (n == 0);
    e.dout   = last_dout;
    e.raddr  = total_reads % DEPTH;
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"},  int'(count), 0);
    chk({tag, "_empty"},  int'(fifo_empty), 1);
    chk({tag, "_aempty"}, int'(fifo_aempty), 1);
    chk({tag, "_full"},   int'(full), 0);
    chk({tag, "_afull"},  int'(afull), 0);
    chk({tag, "_ack"},    int'(wr_ack), 0);
    chk({tag, "_ovf"},    int'(overflow), 0);
    chk({tag, "_udf"},    int'(underflow), 0);
    chk({tag, "_dout"},   int'(fifo_dout), 0);
    chk({tag, "_raddr"},  int'(fifo_MEMRADDR), 0);
  endtask

  // Monitor: every clock edge the DUT presents a new state; compare it with
  // the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge pos_rclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dout",   int'(fifo_dout), e.dout);
        chk("count",  int'(count), e.cnt);
        chk("empty",  int'(fifo_empty), e.empty);
        chk("aempty", int'(fifo_aempty), e.aempty);
        chk("full",   int'(full), e.full);
        chk("afull",  int'(afull), e.afull);
        chk("wr_ack", int'(wr_ack), e.ack);
        chk("ovf",    int'(overflow), e.ovf);
        chk("udf",    int'(underflow), e.udf);
        chk("raddr",  int'(fifo_MEMRADDR), e.raddr);
      end
    end
  end

  initial begin
    int p_wr;
    int p_rd;
    int budget;
    checks     = 0;
    errors     = 0;
    wr_en      = 1'b0;
    din        = '0;
    fifo_rd_en = 1'b0;
    aresetn    = 1'b0;
    model_reset();
    #23;
    check_reset_outputs("rst");
    @(negedge pos_rclk);
    aresetn = 1'b1;

    // Fill to full, then one rejected write.
    for (int i = 0; i < 17; i++) cycle(1'b1, i, 1'b0);
    // Drain in order, then one rejected read.
    for (int i = 0; i < 17; i++) cycle(1'b0, 0, 1'b1);

    // Steady write+read at count=3 across two pointer wraps.
    for (int i = 0; i < 3; i++) cycle(1'b1, 'h100 + i, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 'h200 + i, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1);

    // Empty: simultaneous write and read, no bypass.
    cycle(1'b1, 'h155, 1'b1);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);

    // Full: simultaneous write and read, write dropped.
    for (int i = 0; i < 16; i++) cycle(1'b1, 'h80 + i, 1'b0);
    cycle(1'b1, 'h3FF, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 0, 1'b1);

    // Asynchronous reset mid-burst at count 9.
    for (int i = 0; i < 9; i++) cycle(1'b1, 'h40 + i, 1'b0);
    @(posedge pos_rclk);
    #3;
    wr_en      = 1'b0;
    fifo_rd_en = 1'b0;
    aresetn    = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge pos_rclk);
    aresetn = 1'b1;
    cycle(1'b1, 'h2AA, 1'b0);
    cycle(1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0);

    // Randomized phases with varying read/write bias.
    for (int ph = 0; ph < 8; ph++) begin
      p_wr = $urandom_range(90, 10);
      p_rd = $urandom_range(90, 10);
      for (int i = 0; i < 60; i++) begin
        cycle(($urandom_range(99) < p_wr), $urandom_range(1023),
              ($urandom_range(99) < p_rd));
      end
    end
    cycle(1'b0, 0, 1'b0);

    // Let the monitor consume the remaining predictions, bounded.
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge pos_rclk);
      budget--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ackfifo_sync_ctrl
